// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit: FSM state encoding,
// next-pc source selection and the sequential fetch step.
package pc_pkg;

    // Fetch-side FSM states
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_e;

    // Where the next pc comes from, in priority order FLUSH > JUMP > BRANCH > SEQ
    typedef enum logic [2:0] {
        NONE   = 3'd0,
        FLUSH  = 3'd1,
        JUMP   = 3'd2,
        BRANCH = 3'd3,
        SEQ    = 3'd4
    } pc_src_e;

    // Byte distance between sequential instruction fetches
    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack for pc_unit. Circular buffer: a push onto a full stack
// overwrites the oldest entry, so depth saturates at RAS_DEPTH. A simultaneous
// push and pop on a non-empty stack replaces the top in place.
module pc_ras #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_top,
    output logic            o_empty,
    output logic            o_full
);
    import pc_pkg::*;

    localparam int unsigned IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = IW + 1;

    logic [XLEN-1:0] r_mem [RAS_DEPTH];
    logic [IW-1:0]   r_top_idx;
    logic [CW-1:0]   r_count;

    logic [IW-1:0]   w_idx_d;
    logic [CW-1:0]   w_count_d;
    logic            w_wr_en;
    logic [IW-1:0]   w_wr_idx;

    assign o_top   = r_mem[r_top_idx];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(RAS_DEPTH));

    // Next top pointer, occupancy and write slot from the push/pop request
    always_comb begin
        w_idx_d   = r_top_idx;
        w_count_d = r_count;
        w_wr_en   = 1'b0;
        w_wr_idx  = r_top_idx;
        if (i_push && i_pop && !o_empty) begin
            w_wr_en = 1'b1;
        end else if (i_push) begin
            w_idx_d  = r_top_idx + IW'(1);
            w_wr_idx = w_idx_d;
            w_wr_en  = 1'b1;
            if (!o_full) begin
                w_count_d = r_count + CW'(1);
            end
        end else if (i_pop && !o_empty) begin
            w_idx_d   = r_top_idx - IW'(1);
            w_count_d = r_count - CW'(1);
        end
    end

    // Stack pointer, occupancy and storage registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_top_idx <= '0;
            r_count   <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_top_idx <= w_idx_d;
            r_count   <= w_count_d;
            if (w_wr_en) begin
                r_mem[w_wr_idx] <= i_data;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch address, steps it by PC_STEP when fetch
// accepts it, and applies prioritised redirects (flush > jump > branch).
// Optional return-address stack enabled by defining PC_UNIT_RAS_EN; without it
// ras_push/ras_pop are ignored, ras_empty reads 1 and ras_full reads 0.
module pc_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            flush_valid,
    input  logic [XLEN-1:0] flush_target,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            misaligned,
    output logic            ras_empty,
    output logic            ras_full
);
    import pc_pkg::*;

    pc_state_e       r_state;
    pc_state_e       w_state_d;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_d;
    logic            r_misaligned;
    logic            w_misaligned_d;

    pc_src_e         w_src;
    logic [XLEN-1:0] w_target;
    logic            w_redirect;
    logic            w_advance;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_ras_top;
    logic            w_ras_hit;

    assign w_pc_plus4 = r_pc + XLEN'(PC_STEP);
    assign w_redirect = flush_valid | jump_valid | branch_taken;
    // BOOT never advances; it only exists to hold pc_valid low for one cycle
    assign w_advance  = fetch_ready & ~stall & (r_state != BOOT);

`ifdef PC_UNIT_RAS_EN
    logic w_ras_push;
    logic w_ras_pop;

    // A flush outranks the jump, so its call/return hints must not touch the stack
    assign w_ras_push = jump_valid & ~flush_valid & ras_push;
    assign w_ras_pop  = jump_valid & ~flush_valid & ras_pop;
    assign w_ras_hit  = ras_pop & ~ras_empty;

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_pc_ras (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_ras_push),
        .i_pop   (w_ras_pop),
        .i_data  (w_pc_plus4),
        .o_top   (w_ras_top),
        .o_empty (ras_empty),
        .o_full  (ras_full)
    );
`else
    logic w_unused_ras;

    assign w_unused_ras = ras_push ^ ras_pop;
    assign w_ras_hit    = 1'b0;
    assign w_ras_top    = '0;
    assign ras_empty    = 1'b1;
    assign ras_full     = 1'b0;
`endif

    // Select next-pc source and redirect target by priority
    always_comb begin
        w_src    = NONE;
        w_target = r_pc;
        if (flush_valid) begin
            w_src    = FLUSH;
            w_target = flush_target;
        end else if (jump_valid) begin
            w_src    = JUMP;
            w_target = w_ras_hit ? w_ras_top : jump_target;
        end else if (branch_taken) begin
            w_src    = BRANCH;
            w_target = branch_target;
        end else if (w_advance) begin
            w_src = SEQ;
        end
    end

    // Next pc, misaligned flag and FSM transition
    always_comb begin
        w_pc_d         = r_pc;
        w_state_d      = r_state;
        w_misaligned_d = w_redirect & (|w_target[1:0]);
        unique case (w_src)
            FLUSH, JUMP, BRANCH: w_pc_d = {w_target[XLEN-1:2], 2'b00};
            SEQ:                 w_pc_d = w_pc_plus4;
            default:             w_pc_d = r_pc;
        endcase
        case (r_state)
            BOOT:      w_state_d = RUN;
            RUN, HOLD: w_state_d = (w_src == NONE) ? HOLD : RUN;
            default:   w_state_d = BOOT;
        endcase
    end

    // State, pc and misaligned-pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= BOOT;
            r_pc         <= RESET_VEC;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_pc         <= w_pc_d;
            r_misaligned <= w_misaligned_d;
        end
    end

    assign pc         = r_pc;
    assign pc_valid   = (r_state != BOOT);
    assign misaligned = r_misaligned;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus a randomized phase,
// all compared against a behavioural model (integer pc, queue-based stack).
// Stack scenarios are checked as enabled or disabled following PC_UNIT_RAS_EN.
module tb_pc_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RVEC  = 32'h0000_0000;
`ifdef PC_UNIT_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        flush_valid = 1'b0;
    logic [31:0] flush_target = '0;
    logic        jump_valid = 1'b0;
    logic [31:0] jump_target = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        ras_push = 1'b0;
    logic        ras_pop = 1'b0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        misaligned;
    logic        ras_empty;
    logic        ras_full;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_valid;
    bit          m_mis;
    logic [31:0] m_ras[$];

    pc_unit #(
        .XLEN      (XLEN),
        .RESET_VEC (RVEC),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .fetch_ready   (fetch_ready),
        .flush_valid   (flush_valid),
        .flush_target  (flush_target),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ras_push      (ras_push),
        .ras_pop       (ras_pop),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .misaligned    (misaligned),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = RVEC;
        m_boot  = 1'b1;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        m_ras.delete();
    endtask

    // One rising edge of the specified behaviour, from the inputs as presented
    task automatic model_edge();
        logic [31:0] tgt;
        logic [31:0] ret;
        bit redirect;
        bit adv;
        redirect = flush_valid || jump_valid || branch_taken;
        adv      = fetch_ready && !stall && !m_boot;
        ret      = m_pc + 32'd4;
        tgt      = '0;
        if (flush_valid) tgt = flush_target;
        else if (jump_valid) begin
            if (RAS_ON && ras_pop && m_ras.size() > 0) tgt = m_ras[$];
            else tgt = jump_target;
        end else if (branch_taken) tgt = branch_target;

        if (RAS_ON && jump_valid && !flush_valid) begin
            if (ras_pop && m_ras.size() > 0) void'(m_ras.pop_back());
            if (ras_push) begin
                m_ras.push_back(ret);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
        end

        if (redirect) m_pc = tgt & 32'hFFFF_FFFC;
        else if (adv) m_pc = ret;
        m_mis   = redirect && (tgt[1:0] != 2'b00);
        m_valid = 1'b1;
        m_boot  = 1'b0;
    endtask

    task automatic compare(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".pc_valid"}, 32'(pc_valid), 32'(m_valid));
        chk({tag, ".misaligned"}, 32'(misaligned), 32'(m_mis));
        chk({tag, ".ras_empty"}, 32'(ras_empty), RAS_ON ? 32'(m_ras.size() == 0) : 32'd1);
        chk({tag, ".ras_full"}, 32'(ras_full), RAS_ON ? 32'(m_ras.size() == DEPTH) : 32'd0);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare(tag);
    endtask

    task automatic clear_redirects();
        flush_valid  = 1'b0;
        jump_valid   = 1'b0;
        branch_taken = 1'b0;
        ras_push     = 1'b0;
        ras_pop      = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset state, before any clock edge
        #1;
        compare("reset");
        chk("reset.pc_const", pc, 32'h0);

        // Release reset: one BOOT cycle then 0x0, 0x4, 0x8
        @(posedge clk);
        #1;
        reset       = 1'b0;
        fetch_ready = 1'b1;
        chk("boot.pc_valid", 32'(pc_valid), 32'd0);
        step("boot1");
        chk("seq.pc0", pc, 32'h0);
        step("seq1");
        chk("seq.pc4", pc, 32'h4);
        step("seq2");
        chk("seq.pc8", pc, 32'h8);
        step("seq3");
        step("seq4");
        chk("seq.pc10", pc, 32'h10);

        // Stall for three cycles at 0x10, then resume
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step("stall");
        chk("stall.hold", pc, 32'h10);
        stall = 1'b0;
        step("unstall");
        chk("unstall.pc14", pc, 32'h14);

        // Redirect priority
        flush_valid = 1'b1; flush_target = 32'h100;
        jump_valid = 1'b1;  jump_target = 32'h200;
        branch_taken = 1'b1; branch_target = 32'h300;
        step("prio_all");
        chk("prio.flush", pc, 32'h100);
        flush_valid = 1'b0;
        step("prio_jb");
        chk("prio.jump", pc, 32'h200);
        clear_redirects();

        // Misaligned branch target, one-cycle pulse
        branch_taken = 1'b1; branch_target = 32'h2002;
        step("mis");
        chk("mis.pc", pc, 32'h2000);
        chk("mis.flag", 32'(misaligned), 32'd1);
        clear_redirects();
        step("mis_after");
        chk("mis.clear", 32'(misaligned), 32'd0);

        // Stack hints without jump are ignored
        ras_push = 1'b1;
        step("hint_nojump");
        ras_pop = 1'b1; ras_push = 1'b0;
        step("hint_pop_nojump");
        clear_redirects();

        // Stack: five calls from 0x10..0x50, then five returns
        flush_valid = 1'b1; flush_target = 32'h10;
        step("ras_setup");
        clear_redirects();
        for (int i = 0; i < 5; i++) begin
            jump_valid = 1'b1; ras_push = 1'b1; jump_target = pc + 32'h10;
            step("ras_push");
        end
        clear_redirects();
`ifdef PC_UNIT_RAS_EN
        chk("ras.full", 32'(ras_full), 32'd1);
`endif
        for (int i = 0; i < 5; i++) begin
            jump_valid = 1'b1; ras_pop = 1'b1; jump_target = 32'h800;
            step("ras_pop");
`ifdef PC_UNIT_RAS_EN
            chk("ras.ret", pc, (i < 4) ? (32'h54 - 32'(i) * 32'h10) : 32'h800);
`endif
        end
        clear_redirects();

        // Push and pop together keep depth, redirect to old top
        jump_valid = 1'b1; ras_push = 1'b1; jump_target = 32'h900;
        step("ras_pp_a");
        jump_valid = 1'b1; ras_push = 1'b1; ras_pop = 1'b1; jump_target = 32'hA00;
        step("ras_pp_b");
        clear_redirects();

        // Wrap at top of address space
        flush_valid = 1'b1; flush_target = 32'hFFFF_FFFC;
        step("wrap_set");
        clear_redirects();
        step("wrap");
        chk("wrap.pc", pc, 32'h0);
        chk("wrap.noflag", 32'(misaligned), 32'd0);

        // Randomized phase
        for (int n = 0; n < 400; n++) begin
            stall         = ($urandom_range(0, 3) == 0);
            fetch_ready   = ($urandom_range(0, 3) != 0);
            flush_valid   = ($urandom_range(0, 15) == 0);
            jump_valid    = ($urandom_range(0, 5) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            ras_push      = ($urandom_range(0, 1) == 1);
            ras_pop       = ($urandom_range(0, 1) == 1);
            flush_target  = $urandom;
            jump_target   = $urandom;
            branch_target = $urandom;
            step("rand");
        end
        clear_redirects();

        // Enter HOLD, then assert reset between edges
        fetch_ready = 1'b0;
        stall       = 1'b0;
        step("hold1");
        step("hold2");
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        compare("async_reset");
        chk("async_reset.pc", pc, RVEC);
        @(posedge clk);
        #1;
        compare("reset_held");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
